// File: rtl/packet_pkg.sv
// Shared types for the switch datapath: port count, port index, per-port
// arbitration state and the 16-bit switch word.
package packet_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  // A granted port sits in COOLDOWN during its transmit cycle.
  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } arb_pstate_t;

  // {data[7:0], target[3:0], source[3:0]}
  typedef logic [15:0] word_t;

endpackage

// File: rtl/rr_grant_calc.sv
// Combinational rotating-priority grant calculation. Ports are scanned from
// rr_ptr_i upward (mod 4); a port is granted only if its whole target mask is
// free of lanes already claimed earlier in the scan, so multicast is never split.
module rr_grant_calc
  import packet_pkg::*;
(
  input  logic      [NUM_PORTS-1:0]                eligible_i,
  input  logic      [NUM_PORTS-1:0][NUM_PORTS-1:0] dst_i,
  input  port_idx_t                                rr_ptr_i,
  output logic      [NUM_PORTS-1:0]                grant_o,
  output logic      [NUM_PORTS-1:0][NUM_PORTS-1:0] claim_o,
  output port_idx_t                                rr_ptr_o
);

  logic [NUM_PORTS-1:0] claimed;
  logic                 found;
  port_idx_t            idx;

  // Scan in priority order, claiming lanes; the first grant moves the pointer.
  always_comb begin
    grant_o  = '0;
    claim_o  = '0;
    rr_ptr_o = rr_ptr_i;
    claimed  = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr_i + port_idx_t'(k);
      if (eligible_i[idx] && ((dst_i[idx] & claimed) == '0)) begin
        grant_o[idx] = 1'b1;
        claim_o[idx] = dst_i[idx];
        claimed      = claimed | dst_i[idx];
        if (!found) begin
          found    = 1'b1;
          rr_ptr_o = idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// Crossbar arbiter and egress register for the 4 switch ports.
// Request seen at T -> grant pulse at T+1 -> lane output at T+2.
// Optional per-lane packet counters are built when ARB_STATS_EN is defined.
module switch_arbiter
  import packet_pkg::*;
#(
  parameter int unsigned DATA_W = 16
`ifdef ARB_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0][3:0]        port_dst,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] port_data,
  output logic [NUM_PORTS-1:0]             grant,
  output logic [NUM_PORTS-1:0]             out_valid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0][1:0]        out_src
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]  pkt_cnt
`endif
);

  arb_pstate_t                             pstate_q [NUM_PORTS];
  arb_pstate_t                             pstate_d [NUM_PORTS];
  port_idx_t                               rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]                    grant_q, grant_d;
  logic [NUM_PORTS-1:0]                    lane_hit_q, lane_hit_d;
  logic [NUM_PORTS-1:0][1:0]               lane_src_q, lane_src_d;
  logic [NUM_PORTS-1:0]                    out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0]        out_data_q, out_data_d;
  logic [NUM_PORTS-1:0][1:0]               out_src_q, out_src_d;
  logic [NUM_PORTS-1:0]                    eligible;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]     claim;

  // A port competes only with a live request, a non-empty mask and no grant in flight.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = port_req[i] && (port_dst[i] != 4'b0000) && (pstate_q[i] == READY);
    end
  end

  rr_grant_calc u_rr_grant_calc (
    .eligible_i (eligible),
    .dst_i      (port_dst),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (grant_d),
    .claim_o    (claim),
    .rr_ptr_o   (rr_ptr_d)
  );

  // Per-port state and lane routing for the grant being issued.
  always_comb begin
    lane_hit_d = '0;
    lane_src_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pstate_d[i] = grant_d[i] ? COOLDOWN : READY;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (claim[i][j]) begin
          lane_hit_d[j] = 1'b1;
          lane_src_d[j] = port_idx_t'(i);
        end
      end
    end
  end

  // Egress capture: granted words land on their claimed lanes; idle lanes hold data.
  always_comb begin
    out_valid_d = lane_hit_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (lane_hit_q[j]) begin
        out_data_d[j] = port_data[lane_src_q[j]];
        out_src_d[j]  = lane_src_q[j];
      end
    end
  end

  // Arbitration and egress registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) pstate_q[i] <= READY;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      lane_hit_q  <= '0;
      lane_src_q  <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) pstate_q[i] <= pstate_d[i];
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      lane_hit_q  <= lane_hit_d;
      lane_src_q  <= lane_src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ARB_STATS_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of words sent per lane.
  always_comb begin
    cnt_d = cnt_q;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (out_valid_q[j] && (cnt_q[j] != {CNT_W{1'b1}})) begin
        cnt_d[j] = cnt_q[j] + CNT_W'(1);
      end
    end
  end

  // Packet counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed self-checking bench for switch_arbiter. The counter saturation
// case is compiled in only when ARB_STATS_EN is defined.
module tb_switch_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       port_req;
  logic [3:0][3:0]  port_dst;
  logic [3:0][15:0] port_data;
  logic [3:0]       grant;
  logic [3:0]       out_valid;
  logic [3:0][15:0] out_data;
  logic [3:0][1:0]  out_src;
`ifdef ARB_STATS_EN
  logic [3:0][15:0] pkt_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_req  (port_req),
    .port_dst  (port_dst),
    .port_data (port_data),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef ARB_STATS_EN
    .out_src   (out_src),
    .pkt_cnt   (pkt_cnt)
`else
    .out_src   (out_src)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    port_req  = '0;
    port_dst  = '0;
    port_data = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    // 1: reset values, then a unicast with 2-cycle latency
    rst_n     = 1'b0;
    port_req  = '0;
    port_dst  = '0;
    port_data = '0;
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data[1]), 32'h0);
    check("rst_src", 32'(out_src), 32'h0);
    do_reset();
    port_req     = 4'b0001;
    port_dst[0]  = 4'b0010;
    port_data[0] = 16'hA510;
    step();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_valid_early", 32'(out_valid), 32'h0);
    port_req = 4'b0000;
    step();
    check("t1_valid", 32'(out_valid), 32'h2);
    check("t1_data", 32'(out_data[1]), 32'hA510);
    check("t1_src", 32'(out_src[1]), 32'h0);
    check("t1_grant_once", 32'(grant), 32'h0);
    step();
    check("t1_valid_pulse", 32'(out_valid), 32'h0);
    check("t1_data_hold", 32'(out_data[1]), 32'hA510);

    // 2: four ports contend for lane 0, rotation 0,1,2,3,0
    do_reset();
    port_req  = 4'b1111;
    port_dst  = {4'b0001, 4'b0001, 4'b0001, 4'b0001};
    port_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_grant", 32'(grant), 32'(1) << order[k]);
      if (k > 0) begin
        check("t2_src", 32'(out_src[0]), 32'(order[k - 1]));
        check("t2_data", 32'(out_data[0]), 32'hD000 + 32'(order[k - 1]));
      end
    end
    port_req = '0;
    step();
    step();

    // 3: disjoint masks share a cycle, overlapping multicast waits
    do_reset();
    port_req     = 4'b0111;
    port_dst[0]  = 4'b0011;
    port_dst[1]  = 4'b0100;
    port_dst[2]  = 4'b0010;
    port_data[0] = 16'h1111;
    port_data[1] = 16'h2222;
    port_data[2] = 16'h3333;
    step();
    check("t3_grant", 32'(grant), 32'h3);
    port_req = 4'b0100;
    step();
    check("t3_grant_p2", 32'(grant), 32'h4);
    check("t3_valid", 32'(out_valid), 32'h7);
    check("t3_data0", 32'(out_data[0]), 32'h1111);
    check("t3_data1", 32'(out_data[1]), 32'h1111);
    check("t3_data2", 32'(out_data[2]), 32'h2222);
    check("t3_src", 32'(out_src[2:0]), 32'b01_00_00);
    port_req = 4'b0000;
    step();
    check("t3_valid_p2", 32'(out_valid), 32'h2);
    check("t3_data_p2", 32'(out_data[1]), 32'h3333);
    check("t3_src_p2", 32'(out_src[1]), 32'h2);
    check("t3_data0_hold", 32'(out_data[0]), 32'h1111);

    // 4: empty mask is never granted and does not block others
    port_req     = 4'b0110;
    port_dst[1]  = 4'b0000;
    port_dst[2]  = 4'b1000;
    port_data[2] = 16'h4444;
    step();
    check("t4_grant", 32'(grant), 32'h4);
    port_req = 4'b0010;
    step();
    check("t4_grant_none", 32'(grant), 32'h0);
    check("t4_valid", 32'(out_valid), 32'h8);
    check("t4_data", 32'(out_data[3]), 32'h4444);
    check("t4_src", 32'(out_src[3]), 32'h2);
    step();
    check("t4_never", 32'(grant), 32'h0);
    check("t4_idle", 32'(out_valid), 32'h0);

    // 5: reset while grant=0100 clears state immediately
    port_req     = 4'b0100;
    port_dst[2]  = 4'b0100;
    port_data[2] = 16'h5555;
    step();
    check("t5_grant", 32'(grant), 32'h4);
    rst_n    = 1'b0;
    port_req = '0;
    #1;
    check("t5_grant_clr", 32'(grant), 32'h0);
    check("t5_valid_clr", 32'(out_valid), 32'h0);
    check("t5_data_clr", 32'(out_data[3]), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("t5_no_replay_v", 32'(out_valid), 32'h0);
    check("t5_no_replay_g", 32'(grant), 32'h0);
    step();
    check("t5_no_replay_v2", 32'(out_valid), 32'h0);
    // pointer back at 0: port 0 beats port 3 on a shared lane
    port_req    = 4'b1001;
    port_dst[0] = 4'b0001;
    port_dst[3] = 4'b0001;
    step();
    check("t5_rr_reset", 32'(grant), 32'h1);
    port_req = '0;
    step();
    step();

`ifdef ARB_STATS_EN
    // 6: lane 3 counter saturates
    do_reset();
    port_req = 4'b1111;
    port_dst = {4'b1000, 4'b1000, 4'b1000, 4'b1000};
    for (int k = 0; k < 65545; k++) step();
    check("t6_cnt3_sat", 32'(pkt_cnt[3]), 32'hFFFF);
    check("t6_cnt0", 32'(pkt_cnt[0]), 32'h0);
    port_req = '0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
